// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the MEM stage and an external burst requester share
// one memory port, with a starvation counter bounding either side's wait.
module dm_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_read_i,
  input  logic        cpu_write_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  input  logic        ext_req_i,
  input  logic        ext_we_i,
  input  logic [31:0] ext_addr_i,
  input  logic [4:0]  ext_len_i,
  input  logic [31:0] ext_wdata_i,
  output logic        ext_ack_o,
  output logic [31:0] ext_rdata_o,
  output logic        ext_done_o,
  output logic        ext_busy_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  output logic        dm_read_o,
  output logic        dm_write_o,
  input  logic [31:0] dm_rdata_i
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_t      state_r, state_s;
  logic [2:0]  starve_cnt_r, starve_cnt_s, starve_inc_s;
  logic [4:0]  rem_r, rem_s;
  logic [31:0] baddr_r, baddr_s;
  logic        bwe_r, bwe_s;
  logic        cpu_req_s;

  function automatic logic [4:0] eff_len(input logic [4:0] len);
    if (len == 5'd0) begin
      eff_len = 5'd1;
    end else if (len > 5'd16) begin
      eff_len = 5'd16;
    end else begin
      eff_len = len;
    end
  endfunction

  assign cpu_req_s   = cpu_read_i | cpu_write_i;
  assign cpu_rdata_o = dm_rdata_i;
  assign ext_rdata_o = dm_rdata_i;

  // Port steering and next-state logic; the CPU path stays combinational for zero latency.
  always_comb begin
    state_s      = state_r;
    starve_cnt_s = starve_cnt_r;
    rem_s        = rem_r;
    baddr_s      = baddr_r;
    bwe_s        = bwe_r;
    dm_addr_o    = cpu_addr_i;
    dm_wdata_o   = cpu_wdata_i;
    dm_read_o    = cpu_read_i;
    dm_write_o   = cpu_write_i;
    cpu_stall_o  = 1'b0;
    ext_ack_o    = 1'b0;
    ext_done_o   = 1'b0;
    ext_busy_o   = (state_r == BURST);
    starve_inc_s = (starve_cnt_r >= SMAX) ? SMAX : starve_cnt_r + 3'd1;

    case (state_r)
      IDLE: begin
        if (ext_req_i && (!cpu_req_s || starve_cnt_r == SMAX)) begin
          state_s      = BURST;
          baddr_s      = ext_addr_i & ~32'd3;
          bwe_s        = ext_we_i;
          rem_s        = eff_len(ext_len_i);
          starve_cnt_s = 3'd0;
        end else if (ext_req_i) begin
          starve_cnt_s = starve_inc_s;
        end else begin
          starve_cnt_s = starve_cnt_r;
        end
      end
      BURST: begin
        if (cpu_req_s && starve_cnt_r == SMAX) begin
          starve_cnt_s = 3'd0;
        end else begin
          dm_addr_o    = baddr_r;
          dm_wdata_o   = ext_wdata_i;
          dm_read_o    = !bwe_r;
          dm_write_o   = bwe_r;
          ext_ack_o    = 1'b1;
          cpu_stall_o  = cpu_req_s;
          baddr_s      = baddr_r + 32'd4;
          rem_s        = rem_r - 5'd1;
          starve_cnt_s = cpu_req_s ? starve_inc_s : 3'd0;
          if (rem_r == 5'd1) begin
            ext_done_o   = 1'b1;
            state_s      = IDLE;
            starve_cnt_s = 3'd0;
          end else begin
            ext_done_o   = 1'b0;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Reset silences the port in the same cycle so an aborted burst cannot write.
    if (rst_i) begin
      dm_addr_o   = 32'd0;
      dm_wdata_o  = 32'd0;
      dm_read_o   = 1'b0;
      dm_write_o  = 1'b0;
      cpu_stall_o = 1'b0;
      ext_ack_o   = 1'b0;
      ext_done_o  = 1'b0;
      ext_busy_o  = 1'b0;
    end else begin
      ext_busy_o  = (state_r == BURST);
    end
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      starve_cnt_r <= 3'd0;
      rem_r        <= 5'd0;
      baddr_r      <= 32'd0;
      bwe_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
      rem_r        <= rem_s;
      baddr_r      <= baddr_s;
      bwe_r        <= bwe_s;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: CPU path, bursts, starvation, wrap and reset abort.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, cpu_read, cpu_write, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, dm_rdata;
  logic [4:0]  ext_len;
  logic [31:0] cpu_rdata, ext_rdata, dm_addr, dm_wdata;
  logic        cpu_stall, ext_ack, ext_done, ext_busy, dm_read, dm_write;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign dm_rdata = dm_addr ^ 32'h5A5A_0000;

  dm_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_read_i(cpu_read), .cpu_write_i(cpu_write), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_len_i(ext_len),
    .ext_wdata_i(ext_wdata), .ext_ack_o(ext_ack), .ext_rdata_o(ext_rdata),
    .ext_done_o(ext_done), .ext_busy_o(ext_busy),
    .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_read_o(dm_read), .dm_write_o(dm_write),
    .dm_rdata_i(dm_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h20; cpu_wdata = 32'd0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'd0; ext_len = 5'd0; ext_wdata = 32'd0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if ({dm_read, dm_write, cpu_stall, ext_ack, ext_done, ext_busy} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000", {dm_read, dm_write, cpu_stall, ext_ack, ext_done, ext_busy});
    end
    total++;
    if (dm_addr !== 32'd0 || dm_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_data addr=%h wdata=%h want=0", dm_addr, dm_wdata);
    end
    next_cycle();
    rst = 1'b0; cpu_read = 1'b0;
  endtask

  task automatic test_cpu_load();
    cpu_read = 1'b1; cpu_addr = 32'h10;
    @(negedge clk);
    total++;
    if (dm_read !== 1'b1 || dm_write !== 1'b0 || dm_addr !== 32'h10 || cpu_stall !== 1'b0) begin
      bad++; $display("FAIL cpu_load rd=%b wr=%b addr=%h stall=%b want 1 0 00000010 0", dm_read, dm_write, dm_addr, cpu_stall);
    end
    total++;
    if (cpu_rdata !== (32'h10 ^ 32'h5A5A_0000)) begin
      bad++; $display("FAIL cpu_rdata got=%h want=%h", cpu_rdata, 32'h10 ^ 32'h5A5A_0000);
    end
    next_cycle();
    cpu_read = 1'b0;
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_addr;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h103; ext_len = 5'd4;
    @(negedge clk);
    total++;
    if (ext_ack !== 1'b0 || ext_busy !== 1'b0) begin
      bad++; $display("FAIL rb_req_cycle ack=%b busy=%b want 0 0", ext_ack, ext_busy);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      exp_addr = 32'h100 + 32'(4 * i);
      total++;
      if (ext_ack !== 1'b1 || dm_addr !== exp_addr || dm_read !== 1'b1 || dm_write !== 1'b0) begin
        bad++; $display("FAIL rb_ack%0d ack=%b addr=%h rd=%b wr=%b want 1 %h 1 0", i, ext_ack, dm_addr, dm_read, dm_write, exp_addr);
      end
      total++;
      if (ext_done !== (i == 3) || ext_busy !== 1'b1 || ext_rdata !== (exp_addr ^ 32'h5A5A_0000)) begin
        bad++; $display("FAIL rb_done%0d done=%b busy=%b rdata=%h want %b 1 %h", i, ext_done, ext_busy, ext_rdata, i == 3, exp_addr ^ 32'h5A5A_0000);
      end
    end
    next_cycle();
    ext_req = 1'b0;
    @(negedge clk);
    total++;
    if (ext_busy !== 1'b0 || ext_ack !== 1'b0) begin
      bad++; $display("FAIL rb_after busy=%b ack=%b want 0 0", ext_busy, ext_ack);
    end
  endtask

  task automatic test_starve_write();
    int  w = 0;
    int  first_ack = 0;
    bit  finished = 0;
    bit  exp_ack;
    next_cycle();
    cpu_write = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h200; ext_len = 5'd16; ext_wdata = 32'hD000_0000;
    for (int c = 1; c <= 30 && !finished; c++) begin
      @(negedge clk);
      exp_ack = (c <= 5) ? 1'b0 : (((c - 6) % 5) != 4);
      total++;
      if (ext_ack !== exp_ack || cpu_stall !== exp_ack) begin
        bad++; $display("FAIL sw_grant c=%0d ack=%b stall=%b want %b %b", c, ext_ack, cpu_stall, exp_ack, exp_ack);
      end
      if (exp_ack) begin
        total++;
        if (dm_addr !== 32'h200 + 32'(4 * w) || dm_wdata !== 32'hD000_0000 + 32'(w) || dm_write !== 1'b1 || ext_done !== (w == 15)) begin
          bad++; $display("FAIL sw_word%0d addr=%h wdata=%h wr=%b done=%b want %h %h 1 %b", w, dm_addr, dm_wdata, dm_write, ext_done,
                          32'h200 + 32'(4 * w), 32'hD000_0000 + 32'(w), w == 15);
        end
      end else begin
        total++;
        if (dm_addr !== 32'h40 || dm_wdata !== 32'h1234 || dm_write !== 1'b1 || ext_done !== 1'b0) begin
          bad++; $display("FAIL sw_cpu c=%0d addr=%h wdata=%h wr=%b done=%b want 00000040 00001234 1 0", c, dm_addr, dm_wdata, dm_write, ext_done);
        end
      end
      if (ext_ack === 1'b1) begin
        if (first_ack == 0) first_ack = c;
        if (ext_done === 1'b1) finished = 1;
        w++;
      end
      next_cycle();
      ext_wdata = 32'hD000_0000 + 32'(w);
      if (finished) begin
        ext_req = 1'b0; cpu_write = 1'b0;
      end
    end
    total++;
    if (w != 16 || first_ack != 6 || !finished) begin
      bad++; $display("FAIL sw_summary words=%0d first_ack=%0d finished=%0d want 16 6 1", w, first_ack, finished);
    end
    @(negedge clk);
    total++;
    if (ext_busy !== 1'b0) begin
      bad++; $display("FAIL sw_idle busy=%b want 0", ext_busy);
    end
  endtask

  task automatic test_len_zero();
    next_cycle();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h300; ext_len = 5'd0;
    next_cycle();
    @(negedge clk);
    total++;
    if (ext_ack !== 1'b1 || ext_done !== 1'b1 || dm_addr !== 32'h300) begin
      bad++; $display("FAIL len0_ack ack=%b done=%b addr=%h want 1 1 00000300", ext_ack, ext_done, dm_addr);
    end
    next_cycle();
    ext_req = 1'b0;
    @(negedge clk);
    total++;
    if (ext_ack !== 1'b0 || ext_busy !== 1'b0) begin
      bad++; $display("FAIL len0_after ack=%b busy=%b want 0 0", ext_ack, ext_busy);
    end
  endtask

  task automatic test_wrap();
    next_cycle();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'hFFFF_FFFC; ext_len = 5'd2;
    next_cycle();
    @(negedge clk);
    total++;
    if (ext_ack !== 1'b1 || dm_addr !== 32'hFFFF_FFFC || ext_done !== 1'b0) begin
      bad++; $display("FAIL wrap_w0 ack=%b addr=%h done=%b want 1 fffffffc 0", ext_ack, dm_addr, ext_done);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (ext_ack !== 1'b1 || dm_addr !== 32'h0 || ext_done !== 1'b1) begin
      bad++; $display("FAIL wrap_w1 ack=%b addr=%h done=%b want 1 00000000 1", ext_ack, dm_addr, ext_done);
    end
    next_cycle();
    ext_req = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    next_cycle();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h400; ext_len = 5'd8; ext_wdata = 32'hBEEF_0000;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if (ext_ack !== 1'b1 || dm_addr !== 32'h404 || dm_write !== 1'b1) begin
      bad++; $display("FAIL rst_mid_ack2 ack=%b addr=%h wr=%b want 1 00000404 1", ext_ack, dm_addr, dm_write);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ext_ack !== 1'b0 || dm_write !== 1'b0 || ext_busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_cycle ack=%b wr=%b busy=%b want 0 0 0", ext_ack, dm_write, ext_busy);
    end
    next_cycle();
    rst = 1'b0; ext_req = 1'b0;
    @(negedge clk);
    total++;
    if (ext_busy !== 1'b0 || ext_ack !== 1'b0 || dm_write !== 1'b0) begin
      bad++; $display("FAIL rst_mid_release busy=%b ack=%b wr=%b want 0 0 0", ext_busy, ext_ack, dm_write);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (ext_busy !== 1'b0 || ext_ack !== 1'b0) begin
      bad++; $display("FAIL rst_mid_no_resume busy=%b ack=%b want 0 0", ext_busy, ext_ack);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_load();
    test_read_burst();
    test_starve_write();
    test_len_zero();
    test_wrap();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
